syn_sram_arb: RTL and testbench
===============================

Name: syn_sram_arb

Overview:
- Arbitrates the shared SRAM access bus between the VGA driver (read-only, latency-critical) and the GPU (read/write).
- Sits between both requesters and syn_sram_mem_drvr inside syn_vcortex.
- VGA has fixed priority. A bounded-burst counter stops the GPU from starving.
- Read data returned by the SRAM driver is routed back to the owning requester through an in-order tag FIFO.

Parameters:
- DATA_W, 16, SRAM data width.
- ADDR_W, 18, SRAM word address width.
- TAG_DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of 2).
- VGA_BURST_MAX, 8, consecutive VGA grants allowed while the GPU is waiting.

Ports:
- clk_ir  in  1  system clock
- rst_sync_l  in  1  asynchronous active-low reset
- vga_rd_en  in  1  VGA read request, held until accepted
- vga_addr  in  ADDR_W  VGA read address
- vga_ready  out  1  VGA request accepted this cycle
- vga_rd_valid  out  1  VGA read data valid
- vga_rd_data  out  DATA_W  VGA read data
- gpu_rd_en  in  1  GPU read request, held until accepted
- gpu_wr_en  in  1  GPU write request, held until accepted
- gpu_addr  in  ADDR_W  GPU address
- gpu_wr_data  in  DATA_W  GPU write data
- gpu_ready  out  1  GPU request accepted this cycle
- gpu_rd_valid  out  1  GPU read data valid
- gpu_rd_data  out  DATA_W  GPU read data
- sram_ready  in  1  SRAM driver can accept a command
- sram_rd_en  out  1  registered read command
- sram_wr_en  out  1  registered write command
- sram_addr  out  ADDR_W  registered address
- sram_wr_data  out  DATA_W  registered write data
- sram_rd_valid  in  1  read data from SRAM driver, in order
- sram_rd_data  in  DATA_W  read data
- tag_err  out  1  sticky: sram_rd_valid received with tag FIFO empty

Behaviour:
- Reset (async, rst_sync_l=0):
  - All outputs 0.
  - Tag FIFO emptied.
  - Burst counter cleared.
  - tag_err cleared. A reset is the only way to clear tag_err.
- Request definitions: vga_req = vga_rd_en; gpu_req = gpu_rd_en|gpu_wr_en. If gpu_rd_en and gpu_wr_en are both high, the request is treated as a write.
- Issue is blocked when sram_ready=0. It is also blocked for a read when the tag FIFO is full. A blocked cycle makes no grant.
- Grant (combinational, same cycle as the request):
  - vga_req only: grant VGA.
  - gpu_req only: grant GPU.
  - Both requesting: grant VGA unless burst_cnt==VGA_BURST_MAX, in which case grant GPU.
  - If the preferred requester is blocked (a read with the FIFO full), the other requester is not granted that cycle. Strict order is preserved.
- Accept: xx_ready=1 exactly in the grant cycle. The requester drops or changes its request at the following edge.
- Registered outputs:
  - On accept, sram_* take the granted command at the next rising edge, so there is 1-cycle issue latency.
  - With no accept, sram_rd_en and sram_wr_en are 0 and sram_addr/sram_wr_data hold their last values.
- burst_cnt:
  - Increments (saturating at VGA_BURST_MAX) on a VGA grant while gpu_req=1.
  - Clears on a GPU grant.
  - Clears in any cycle where gpu_req=0.
- Tag FIFO:
  - On each read accept, push 1 bit (0=VGA, 1=GPU). Writes push nothing.
  - On sram_rd_valid, pop the head and drive xx_rd_valid/xx_rd_data for that owner at the next edge. Return path latency is 1 cycle.
  - rd_data is registered and holds its value when not valid.
- Push and pop in the same cycle: occupancy is unchanged. A push into a full FIFO is allowed only if a pop happens in the same cycle. Full gating uses count==TAG_DEPTH && !sram_rd_valid.
- sram_rd_valid with FIFO empty: data is dropped, no xx_rd_valid is asserted, and tag_err is set.
- Pointers wrap modulo TAG_DEPTH. Count width is clog2(TAG_DEPTH)+1.
- Reset mid-transaction: in-flight reads are lost. The late returns set tag_err, which software treats as expected after a VGA soft reset.

Test Plan:
- Only GPU writes addr 0x00010, data 0xABCD, with sram_ready=1 -> gpu_ready=1 in cycle N; sram_wr_en=1, sram_addr=0x00010, sram_wr_data=0xABCD in N+1; no tag push.
- VGA and GPU read continuously with VGA_BURST_MAX=8 -> 8 VGA grants, 1 GPU grant, then repeat; burst_cnt never exceeds 8.
- 4 VGA reads are issued with no returns (TAG_DEPTH=4) -> 5th read blocked (vga_ready=0); pulse sram_rd_valid with 0x1234 -> vga_rd_valid next cycle with 0x1234, and the 5th read accepted in the same cycle as the pop.
- Interleaved reads V,G,V with returns 0x1111, 0x2222, 0x3333 -> vga_rd_data=0x1111, gpu_rd_data=0x2222, vga_rd_data=0x3333, in order.
- sram_ready=0 for 3 cycles with both requesting -> no ready, no sram commands, burst_cnt unchanged.
- 2 reads outstanding, then assert rst_sync_l=0 mid-stream and release, then 2 returns arrive -> no xx_rd_valid; tag_err=1 and stays 1 until the next reset.

Source files
------------

// File: rtl/syn_sram_arb.sv
// syn_sram_arb: shared SRAM bus arbiter between the VGA reader and the GPU.
// VGA has fixed priority, and a burst counter bounds how long the GPU waits.
// Read data returns in order. A 1-bit tag FIFO records which requester owns
// each outstanding read, so each return can be routed to that requester.
module syn_sram_arb #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 18,
  parameter int TAG_DEPTH     = 4,   // power of 2, >= 2
  parameter int VGA_BURST_MAX = 8
) (
  input  logic              clk_ir,
  input  logic              rst_sync_l,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ready,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  input  logic              gpu_rd_en,
  input  logic              gpu_wr_en,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wr_data,
  output logic              gpu_ready,
  output logic              gpu_rd_valid,
  output logic [DATA_W-1:0] gpu_rd_data,
  input  logic              sram_ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              sram_rd_valid,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              tag_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(VGA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(TAG_DEPTH);
  localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(VGA_BURST_MAX);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sram_cmd_t;

  logic                 vga_req, gpu_req, gpu_is_wr;
  logic                 pref_gpu, pref_rd, blocked, fifo_blk;
  logic                 grant_vga, grant_gpu;
  logic                 push, pop, head;
  logic [BC_W-1:0]      burst_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     tag_cnt;
  sram_cmd_t            cmd_q;

  assign vga_req   = vga_rd_en;
  assign gpu_req   = gpu_rd_en | gpu_wr_en;
  assign gpu_is_wr = gpu_wr_en;   // rd+wr together counts as a write

  // Full only blocks when no return frees a slot in the same cycle
  assign fifo_blk = (tag_cnt == FIFO_FULL) && !sram_rd_valid;

  // Grant: the preferred requester is granted, or nobody is (strict order)
  always_comb begin
    pref_gpu  = gpu_req && (!vga_req || (burst_cnt == BURST_MAX));
    pref_rd   = pref_gpu ? !gpu_is_wr : vga_req;
    blocked   = !sram_ready || (pref_rd && fifo_blk) || !rst_sync_l;
    grant_vga = vga_req && !pref_gpu && !blocked;
    grant_gpu = pref_gpu && !blocked;
  end

  assign vga_ready = grant_vga;
  assign gpu_ready = grant_gpu;

  assign push = grant_vga || (grant_gpu && !gpu_is_wr);
  assign pop  = sram_rd_valid && (tag_cnt != '0);
  assign head = tag_mem[rd_ptr];

  // Count consecutive VGA grants while the GPU waits; saturates at the limit
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l)                              burst_cnt <= '0;
    else if (!gpu_req || grant_gpu)               burst_cnt <= '0;
    else if (grant_vga && burst_cnt < BURST_MAX)  burst_cnt <= burst_cnt + BC_W'(1);
  end

  // Register the granted command onto the SRAM driver bus
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      cmd_q <= '0;
    end else begin
      cmd_q.rd <= push;
      cmd_q.wr <= grant_gpu && gpu_is_wr;
      if (grant_vga)      cmd_q.addr <= vga_addr;
      else if (grant_gpu) cmd_q.addr <= gpu_addr;
      if (grant_gpu && gpu_is_wr) cmd_q.data <= gpu_wr_data;
    end
  end

  assign sram_rd_en   = cmd_q.rd;
  assign sram_wr_en   = cmd_q.wr;
  assign sram_addr    = cmd_q.addr;
  assign sram_wr_data = cmd_q.data;

  // Owner-tag FIFO: 0 = VGA, 1 = GPU; pointers wrap naturally (power of 2)
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_gpu;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Route returned data to its owner; data regs hold between returns
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      vga_rd_valid <= 1'b0;
      gpu_rd_valid <= 1'b0;
      vga_rd_data  <= '0;
      gpu_rd_data  <= '0;
    end else begin
      vga_rd_valid <= pop && !head;
      gpu_rd_valid <= pop && head;
      if (pop && !head) vga_rd_data <= sram_rd_data;
      if (pop && head)  gpu_rd_data <= sram_rd_data;
    end
  end

  // Sticky: a return arrived with no read outstanding (e.g. after a reset)
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l)                          tag_err <= 1'b0;
    else if (sram_rd_valid && tag_cnt == '0)  tag_err <= 1'b1;
  end

endmodule

// File: tb/tb_syn_sram_arb.sv
// Directed bench for syn_sram_arb: inputs change on the falling edge,
// ready is sampled before the rising edge, registered outputs just after it.
module tb_syn_sram_arb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;

  logic              clk_ir = 1'b0;
  logic              rst_sync_l;
  logic              vga_rd_en, vga_ready, vga_rd_valid;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic              gpu_rd_en, gpu_wr_en, gpu_ready, gpu_rd_valid;
  logic [ADDR_W-1:0] gpu_addr;
  logic [DATA_W-1:0] gpu_wr_data, gpu_rd_data;
  logic              sram_ready, sram_rd_en, sram_wr_en, sram_rd_valid, tag_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wr_data, sram_rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int outst    = 0;   // reads issued but not yet returned, tracked by the bench

  syn_sram_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_DEPTH(4), .VGA_BURST_MAX(8)) dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
    .vga_rd_en(vga_rd_en), .vga_addr(vga_addr), .vga_ready(vga_ready),
    .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
    .gpu_rd_en(gpu_rd_en), .gpu_wr_en(gpu_wr_en), .gpu_addr(gpu_addr),
    .gpu_wr_data(gpu_wr_data), .gpu_ready(gpu_ready),
    .gpu_rd_valid(gpu_rd_valid), .gpu_rd_data(gpu_rd_data),
    .sram_ready(sram_ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
    .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data), .tag_err(tag_err)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic clear_inputs();
    vga_rd_en = 0; vga_addr = '0; gpu_rd_en = 0; gpu_wr_en = 0;
    gpu_addr = '0; gpu_wr_data = '0; sram_ready = 1; sram_rd_valid = 0;
    sram_rd_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_ir); rst_sync_l = 0; clear_inputs();
    repeat (2) @(negedge clk_ir);
    rst_sync_l = 1;
    outst = 0;
  endtask

  // One cycle with both requesters reading; returns keep the FIFO near-empty
  task automatic both_cycle(input logic rdy, output logic gv, output logic gg,
                            output logic srd);
    @(negedge clk_ir);
    vga_rd_en = 1; gpu_rd_en = 1; gpu_wr_en = 0; sram_ready = rdy;
    sram_rd_valid = (outst > 0); sram_rd_data = 16'h0F0F;
    if (outst > 0) outst--;
    #1; gv = vga_ready; gg = gpu_ready;
    if (gv || gg) outst++;
    @(posedge clk_ir); #1; srd = sram_rd_en;
  endtask

  task automatic drain();
    vga_rd_en = 0; gpu_rd_en = 0; gpu_wr_en = 0; sram_ready = 1;
    while (outst > 0) begin
      @(negedge clk_ir); sram_rd_valid = 1; outst--;
    end
    @(negedge clk_ir); sram_rd_valid = 0;
  endtask

  task automatic test_reset();
    logic [2*DATA_W+ADDR_W+DATA_W+6:0] all_out;
    rst_sync_l = 0; clear_inputs();
    vga_rd_en = 1; gpu_wr_en = 1;
    repeat (2) @(negedge clk_ir);
    #1;
    n_checks++;
    if ({vga_ready, gpu_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b exp 00", {vga_ready, gpu_ready});
    end
    all_out = {sram_rd_en, sram_wr_en, sram_addr, sram_wr_data, vga_rd_valid,
               gpu_rd_valid, vga_rd_data, gpu_rd_data, tag_err};
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    clear_inputs();
    @(negedge clk_ir); rst_sync_l = 1;
  endtask

  task automatic test_gpu_write();
    @(negedge clk_ir);
    gpu_wr_en = 1; gpu_rd_en = 1; gpu_addr = 18'h00010; gpu_wr_data = 16'hABCD;
    #1;
    n_checks++;
    if ({vga_ready, gpu_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_ready got %b exp 01", {vga_ready, gpu_ready});
    end
    @(posedge clk_ir); #1;
    gpu_wr_en = 0; gpu_rd_en = 0;
    n_checks++;
    if ({sram_wr_en, sram_rd_en, sram_addr, sram_wr_data} !== {2'b10, 18'h00010, 16'hABCD}) begin
      n_fail++; $display("FAIL wr_issue got wr=%b rd=%b a=%h d=%h exp wr=1 rd=0 a=00010 d=abcd",
                         sram_wr_en, sram_rd_en, sram_addr, sram_wr_data);
    end
    @(posedge clk_ir); #1;
    n_checks++;
    if ({sram_wr_en, sram_rd_en, sram_addr, sram_wr_data} !== {2'b00, 18'h00010, 16'hABCD}) begin
      n_fail++; $display("FAIL wr_hold got wr=%b rd=%b a=%h d=%h exp 0 0 00010 abcd",
                         sram_wr_en, sram_rd_en, sram_addr, sram_wr_data);
    end
  endtask

  // Relies on the preceding write having pushed no tag
  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ir); vga_rd_en = 1; vga_addr = 18'h100 + 18'(i);
      #1;
      n_checks++;
      if (vga_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_fill%0d_ready got %b exp 1", i, vga_ready);
      end
      @(posedge clk_ir); #1;
      n_checks++;
      if ({sram_rd_en, sram_addr} !== {1'b1, 18'h100 + 18'(i)}) begin
        n_fail++; $display("FAIL full_fill%0d_issue got rd=%b a=%h exp rd=1 a=%h",
                           i, sram_rd_en, sram_addr, 18'h100 + 18'(i));
      end
    end
    @(negedge clk_ir); vga_addr = 18'h104;
    #1;
    n_checks++;
    if (vga_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_blocked got %b exp 0", vga_ready);
    end
    @(posedge clk_ir); #1;
    n_checks++;
    if ({sram_rd_en, sram_addr} !== {1'b0, 18'h103}) begin
      n_fail++; $display("FAIL full_no_issue got rd=%b a=%h exp rd=0 a=00103", sram_rd_en, sram_addr);
    end
    @(negedge clk_ir); sram_rd_valid = 1; sram_rd_data = 16'h1234;
    #1;
    n_checks++;
    if (vga_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_accept got %b exp 1", vga_ready);
    end
    @(posedge clk_ir); #1;
    vga_rd_en = 0;
    n_checks++;
    if ({vga_rd_valid, gpu_rd_valid, vga_rd_data, sram_rd_en, sram_addr} !==
        {2'b10, 16'h1234, 1'b1, 18'h104}) begin
      n_fail++; $display("FAIL full_return got v=%b g=%b d=%h rd=%b a=%h exp 1 0 1234 1 00104",
                         vga_rd_valid, gpu_rd_valid, vga_rd_data, sram_rd_en, sram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ir); sram_rd_valid = 1; sram_rd_data = 16'h5000 + 16'(i);
      @(posedge clk_ir); #1;
      n_checks++;
      if ({vga_rd_valid, gpu_rd_valid, vga_rd_data} !== {2'b10, 16'h5000 + 16'(i)}) begin
        n_fail++; $display("FAIL full_drain%0d got v=%b g=%b d=%h exp 1 0 %h",
                           i, vga_rd_valid, gpu_rd_valid, vga_rd_data, 16'h5000 + 16'(i));
      end
    end
    @(negedge clk_ir); sram_rd_valid = 0;
  endtask

  task automatic test_interleave();
    logic [1:0] exp_rdy [3];
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ir);
      vga_rd_en = (i != 1); gpu_rd_en = (i == 1);
      vga_addr = 18'h200 + 18'(i); gpu_addr = 18'h300;
      #1;
      n_checks++;
      if ({vga_ready, gpu_ready} !== exp_rdy[i]) begin
        n_fail++; $display("FAIL il_issue%0d got %b exp %b", i, {vga_ready, gpu_ready}, exp_rdy[i]);
      end
    end
    @(negedge clk_ir); vga_rd_en = 0; gpu_rd_en = 0;
    sram_rd_valid = 1; sram_rd_data = 16'h1111;
    @(posedge clk_ir); #1;
    n_checks++;
    if ({vga_rd_valid, gpu_rd_valid, vga_rd_data} !== {2'b10, 16'h1111}) begin
      n_fail++; $display("FAIL il_ret0 got v=%b g=%b d=%h exp 1 0 1111", vga_rd_valid, gpu_rd_valid, vga_rd_data);
    end
    @(negedge clk_ir); sram_rd_data = 16'h2222;
    @(posedge clk_ir); #1;
    n_checks++;
    if ({vga_rd_valid, gpu_rd_valid, gpu_rd_data, vga_rd_data} !== {2'b01, 16'h2222, 16'h1111}) begin
      n_fail++; $display("FAIL il_ret1 got v=%b g=%b gd=%h vd=%h exp 0 1 2222 1111",
                         vga_rd_valid, gpu_rd_valid, gpu_rd_data, vga_rd_data);
    end
    @(negedge clk_ir); sram_rd_data = 16'h3333;
    @(posedge clk_ir); #1;
    n_checks++;
    if ({vga_rd_valid, gpu_rd_valid, vga_rd_data, gpu_rd_data} !== {2'b10, 16'h3333, 16'h2222}) begin
      n_fail++; $display("FAIL il_ret2 got v=%b g=%b vd=%h gd=%h exp 1 0 3333 2222",
                         vga_rd_valid, gpu_rd_valid, vga_rd_data, gpu_rd_data);
    end
    @(negedge clk_ir); sram_rd_valid = 0;
    #1;
    n_checks++;
    if (tag_err !== 1'b0) begin
      n_fail++; $display("FAIL il_tag_err got %b exp 0", tag_err);
    end
  endtask

  task automatic test_burst();
    logic gv, gg, srd;
    logic [1:0] exp;
    for (int i = 0; i < 18; i++) begin
      both_cycle(1'b1, gv, gg, srd);
      exp = ((i % 9) == 8) ? 2'b01 : 2'b10;
      n_checks++;
      if ({gv, gg} !== exp) begin
        n_fail++; $display("FAIL burst_cyc%0d got %b exp %b", i, {gv, gg}, exp);
      end
    end
    drain();
  endtask

  // Three VGA grants, a 3-cycle stall, then five more VGA grants before the GPU
  task automatic test_sram_stall();
    logic gv, gg, srd;
    logic [1:0] exp;
    for (int i = 0; i < 3; i++) begin
      both_cycle(1'b1, gv, gg, srd);
      n_checks++;
      if ({gv, gg} !== 2'b10) begin
        n_fail++; $display("FAIL stall_pre%0d got %b exp 10", i, {gv, gg});
      end
    end
    for (int i = 0; i < 3; i++) begin
      both_cycle(1'b0, gv, gg, srd);
      n_checks++;
      if ({gv, gg, srd, sram_wr_en} !== 4'b0000) begin
        n_fail++; $display("FAIL stall_blk%0d got rdy=%b rd=%b wr=%b exp 00 0 0", i, {gv, gg}, srd, sram_wr_en);
      end
    end
    for (int i = 0; i < 6; i++) begin
      both_cycle(1'b1, gv, gg, srd);
      exp = (i == 5) ? 2'b01 : 2'b10;
      n_checks++;
      if ({gv, gg} !== exp) begin
        n_fail++; $display("FAIL stall_post%0d got %b exp %b", i, {gv, gg}, exp);
      end
    end
    drain();
    #1;
    n_checks++;
    if (tag_err !== 1'b0) begin
      n_fail++; $display("FAIL stall_tag_err got %b exp 0", tag_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ir); vga_rd_en = 1; vga_addr = 18'h400 + 18'(i);
    end
    @(negedge clk_ir); vga_rd_en = 0; rst_sync_l = 0;
    #1;
    n_checks++;
    if ({sram_rd_en, sram_addr, vga_rd_valid, tag_err} !== '0) begin
      n_fail++; $display("FAIL mid_reset got rd=%b a=%h v=%b err=%b exp all 0",
                         sram_rd_en, sram_addr, vga_rd_valid, tag_err);
    end
    @(negedge clk_ir); rst_sync_l = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ir); sram_rd_valid = 1; sram_rd_data = 16'hDEAD;
      @(posedge clk_ir); #1;
      n_checks++;
      if ({vga_rd_valid, gpu_rd_valid, tag_err} !== 3'b001) begin
        n_fail++; $display("FAIL mid_late%0d got v=%b g=%b err=%b exp 0 0 1",
                           i, vga_rd_valid, gpu_rd_valid, tag_err);
      end
    end
    // A normal read/return afterwards must not clear the sticky error
    @(negedge clk_ir); sram_rd_valid = 0; vga_rd_en = 1;
    @(negedge clk_ir); vga_rd_en = 0; sram_rd_valid = 1; sram_rd_data = 16'h7777;
    @(posedge clk_ir); #1;
    n_checks++;
    if ({vga_rd_valid, vga_rd_data, tag_err} !== {1'b1, 16'h7777, 1'b1}) begin
      n_fail++; $display("FAIL mid_sticky got v=%b d=%h err=%b exp 1 7777 1", vga_rd_valid, vga_rd_data, tag_err);
    end
    @(negedge clk_ir); sram_rd_valid = 0;
    repeat (3) @(negedge clk_ir);
    n_checks++;
    if (tag_err !== 1'b1) begin
      n_fail++; $display("FAIL mid_hold got %b exp 1", tag_err);
    end
    do_reset();
    #1;
    n_checks++;
    if (tag_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_clear got %b exp 0", tag_err);
    end
  endtask

  initial begin
    test_reset();
    test_gpu_write();
    test_fifo_full();
    test_interleave();
    test_burst();
    test_sram_stall();
    test_reset_mid();
    repeat (2) @(negedge clk_ir);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
